load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the request and memory address.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  CPU load/store request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  qualifies rsp_valid; misaligned or reserved-size request.
REQ-014 mem_addr  out  ADDR_W  byte address to data memory.
REQ-015 mem_wdata  out  8  byte to write.
REQ-016 mem_we  out  1  byte write strobe, sampled by memory on clk rising edge.
REQ-017 mem_re  out  1  byte read qualifier.
REQ-018 mem_rdata  in  8  byte at mem_addr, combinational (same-cycle) from memory.

Function
REQ-019 States: IDLE, ACCESS, RESP, ERR; req_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: request accepted on an edge with req_valid && req_ready; all request fields latched then; inputs ignored outside acceptance.
REQ-021 Byte count N = 1/2/4 for size 00/01/10; little-endian: byte k = data[8k+7:8k].
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go IDLE->ERR; no memory strobe asserted.
REQ-023 ERR lasts one cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0; then IDLE.
REQ-024 ACCESS lasts exactly N cycles; in access cycle k: mem_addr = base+k, mem_re=1 for loads, mem_we=1 and mem_wdata=byte k for stores.
REQ-025 Loads capture mem_rdata into byte k of an internal 32-bit buffer at the end of access cycle k.
REQ-026 After cycle N-1, ACCESS->RESP; RESP lasts one cycle: rsp_valid=1, rsp_err=0, then IDLE.
REQ-027 rsp_rdata: byte/half extended per req_unsigned from bit 7/15; word passed unchanged; stores 0.
REQ-028 Latency: rsp_valid asserted N+1 cycles after the accepting edge; ERR response 1 cycle after it.
REQ-029 Back-to-back: next request acceptable the cycle after rsp_valid; max throughput one request per N+2 cycles.
REQ-030 mem_we, mem_re, rsp_valid, rsp_err SHALL be 0 in every cycle not listed above; mem_addr/mem_wdata are don't-care then but SHALL hold last value.
REQ-031 Address arithmetic is modulo 2^ADDR_W.
REQ-032 No response backpressure; rsp_valid is a pulse.

Reset
REQ-033 rsp_valid, rsp_err, mem_we, mem_re, and req_ready SHALL be 0 immediately while rst_n=0; state SHALL be IDLE; rsp_rdata, mem_addr, mem_wdata, and the buffer SHALL be 0.
REQ-034 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-035 Reset mid-ACCESS aborts without a response; bytes already stored remain written.

Structure
REQ-036 Package lsu_pkg: size encodings, state enum, byte-count function.
REQ-037 Sub-module lsu_extend: combinational byte/half sign/zero extension.

Verification
REQ-038 Word store 0xDEADBEEF at 0x10 -> 4 cycles of mem_we, addr 0x10..0x13, data EF,BE,AD,DE; rsp_valid at cycle 5, rdata 0.
REQ-039 Signed byte load at 0x07, memory byte 0x80 -> rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Half load at 0x03 -> rsp_err=1 one cycle after acceptance, no mem_re/mem_we.
REQ-041 Word load at 0x20, bytes 11,22,33,44 -> rsp_rdata 0x44332211; back-to-back byte store accepted the cycle after rsp_valid.
REQ-042 rst_n low during cycle 2 of a word store -> mem_we drops immediately, no rsp_valid; req_ready=1 one edge after release.
REQ-043 req_size 11 -> rsp_err=1, rsp_rdata 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the byte-serial load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: byte_count = 3'd1;
            SIZE_HALF: byte_count = 3'd2;
            default:   byte_count = 3'd4;
        endcase
    endfunction

    // Reserved size or an address not aligned to the access size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = addr_lo[0];
            SIZE_WORD: req_bad = (addr_lo != 2'b00);
            default:   req_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_BYTE: data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
            SIZE_HALF: data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one memory byte per cycle, one response pulse per request.
//   state  | meaning
//   IDLE   | ready for a request (once the post-reset enable flop has set)
//   ACCESS | one byte strobed per cycle, cnt_q counts remaining bytes down to 0
//   RESP   | one-cycle completion pulse with extended load data
//   ERR    | one-cycle error pulse for misaligned or reserved-size requests
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              ready_en_q, ready_en_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       ext_data;

    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    if (req_bad(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = 2'(byte_count(req_size) - 3'd1);
                        idx_d   = 2'd0;
                        addr_d  = req_addr;
                        if (req_write) wdata_d = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (!write_q) buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                // Address and write byte advance only between bytes so both hold after the last one.
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d  = cnt_q - 2'd1;
                    idx_d  = idx_q + 2'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (write_q) wdata_d = {8'h00, wdata_q[31:8]};
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            cnt_q      <= 2'd0;
            idx_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            buf_q      <= 32'h0;
            write_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
        end
    end

    lsu_extend u_extend (
        .data_i     (buf_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ext_data)
    );

    // ready_en_q keeps req_ready low through reset and until the first edge after release.
    assign req_ready = (state_q == ST_IDLE) && ready_en_q;
    assign mem_re    = (state_q == ST_ACCESS) && !write_q;
    assign mem_we    = (state_q == ST_ACCESS) && write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q[7:0];
    assign rsp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign rsp_err   = (state_q == ST_ERR);
    assign rsp_rdata = ((state_q == ST_RESP) && !write_q) ? ext_data : 32'h0;

endmodule
